// File: rtl/exp_mul_axi4lite_master.sv
// exp_mul_axi4lite_master: AXI4-Lite initiator that writes A/B/SELECT/START, polls DONE, reads P.
module exp_mul_axi4lite_master #(
    parameter logic [31:0] BASE_ADDR  = 32'h7c80_0000,
    parameter int          POLL_LIMIT = 1024
) (
    input  logic        M_AXI_ACLK,
    input  logic        M_AXI_ARESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic        cmd_sel,
    output logic        result_valid,
    output logic [31:0] result_data,
    output logic [1:0]  result_err,
    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic        M_AXI_BVALID,
    input  logic [1:0]  M_AXI_BRESP,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE_OUT} state_t;
    state_t state, state_nxt;
    logic [1:0]  step;
    logic        aw_done, w_done, b_got, b_bad_q, r_got, r_bad_q, tgt_p, sel_q;
    logic [31:0] a_q, b_q, r_data_q, poll_cnt, r_word;
    logic        aw_hs, w_hs, b_fire, b_bad, r_fire, r_bad, poll_last;

    assign aw_hs     = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs      = M_AXI_WVALID & M_AXI_WREADY;
    // a response may arrive early; it is parked in *_got until its state consumes it
    assign b_fire    = b_got | (M_AXI_BVALID & M_AXI_BREADY);
    assign b_bad     = b_got ? b_bad_q : (M_AXI_BRESP != 2'b00);
    assign r_fire    = r_got | (M_AXI_RVALID & M_AXI_RREADY);
    assign r_bad     = r_got ? r_bad_q : (M_AXI_RRESP != 2'b00);
    assign r_word    = r_got ? r_data_q : M_AXI_RDATA;
    assign poll_last = (poll_cnt + 32'd1) == 32'(POLL_LIMIT);

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET)
        if (M_AXI_ARESET) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (cmd_valid) state_nxt = WR_REQ;
            WR_REQ:   if ((aw_done | aw_hs) && (w_done | w_hs)) state_nxt = WR_RESP;
            WR_RESP:  if (b_fire) state_nxt = b_bad ? DONE_OUT : (step == 2'd3) ? RD_REQ : WR_REQ;
            RD_REQ:   if (M_AXI_ARREADY) state_nxt = RD_RESP;
            RD_RESP:  if (r_fire) state_nxt = (r_bad || tgt_p) ? DONE_OUT :
                                              r_word[0] ? RD_REQ : poll_last ? DONE_OUT : RD_REQ;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready     = (state == IDLE) && !M_AXI_ARESET;
        M_AXI_AWVALID = (state == WR_REQ) && !aw_done;
        M_AXI_AWADDR  = (state == WR_REQ) ? BASE_ADDR + {28'd0, step, 2'b00} : 32'd0;
        M_AXI_WVALID  = (state == WR_REQ) && !w_done;
        M_AXI_WDATA   = (state != WR_REQ) ? 32'd0 : (step == 2'd0) ? a_q : (step == 2'd1) ? b_q :
                        (step == 2'd2) ? {31'd0, sel_q} : 32'd1;
        M_AXI_WSTRB   = (state == WR_REQ) ? 4'hF : 4'h0;
        M_AXI_BREADY  = (state == WR_REQ || state == WR_RESP) && !b_got;
        M_AXI_ARVALID = (state == RD_REQ);
        M_AXI_ARADDR  = (state == RD_REQ) ? BASE_ADDR + (tgt_p ? 32'h10 : 32'h14) : 32'd0;
        M_AXI_RREADY  = (state == RD_REQ || state == RD_RESP) && !r_got;
        result_valid  = (state == DONE_OUT);
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET)
        if (M_AXI_ARESET) begin
            {step, aw_done, w_done, b_got, b_bad_q, r_got, r_bad_q, tgt_p, sel_q} <= '0;
            {a_q, b_q, r_data_q, poll_cnt, result_data} <= '0;
            result_err <= 2'b00;
        end else begin
            if (state == IDLE && cmd_valid) begin
                a_q   <= cmd_a;
                b_q   <= cmd_b;
                sel_q <= cmd_sel;
                step  <= 2'd0;
            end
            aw_done <= (state == WR_REQ) && (state_nxt == WR_REQ) && (aw_done | aw_hs);
            w_done  <= (state == WR_REQ) && (state_nxt == WR_REQ) && (w_done | w_hs);
            if (state == WR_REQ && M_AXI_BVALID && M_AXI_BREADY) begin
                b_got   <= 1'b1;
                b_bad_q <= M_AXI_BRESP != 2'b00;
            end else if (state == WR_RESP && b_fire) b_got <= 1'b0;
            if (state == RD_REQ && M_AXI_RVALID && M_AXI_RREADY) begin
                r_got    <= 1'b1;
                r_bad_q  <= M_AXI_RRESP != 2'b00;
                r_data_q <= M_AXI_RDATA;
            end else if (state == RD_RESP && r_fire) r_got <= 1'b0;
            if (state == WR_RESP && b_fire) begin
                if (b_bad) result_err <= 2'b01;
                else if (step != 2'd3) step <= step + 2'd1;
                else begin
                    poll_cnt <= 32'd0;
                    tgt_p    <= 1'b0;
                end
            end
            if (state == RD_RESP && r_fire) begin
                if (r_bad) result_err <= 2'b01;
                else if (tgt_p) begin
                    result_data <= r_word;
                    result_err  <= 2'b00;
                end else if (r_word[0]) tgt_p <= 1'b1;
                else begin
                    poll_cnt <= poll_cnt + 32'd1;
                    if (poll_last) result_err <= 2'b10;
                end
            end
        end
endmodule

// File: tb/tb_exp_mul_axi4lite_master.sv
// tb_exp_mul_axi4lite_master: directed jobs against a behavioural exponent/multiplier slave.
module tb_exp_mul_axi4lite_master;
    localparam logic [31:0] BASE = 32'h7c80_0000;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_ready, cmd_sel, result_valid;
    logic [31:0] cmd_a, cmd_b, result_data;
    logic [1:0]  result_err, bresp, rresp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;

    exp_mul_axi4lite_master #(.BASE_ADDR(BASE), .POLL_LIMIT(4)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .result_valid(result_valid), .result_data(result_data), .result_err(result_err),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BVALID(bvalid), .M_AXI_BRESP(bresp), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    // slave knobs: DONE reads 1 on read number done_after (0 = never); bp delays WREADY
    int          done_after = 3;
    bit          bp = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    logic        aw_seen = 0, w_seen = 0, s_sel = 0, aw_pend = 0, w_pend = 0, split_seen = 0;
    logic [31:0] aw_q = 0, w_q = 0, s_a = 0, s_b = 0, aw_prev = 0, w_prev = 0, wa, wd;
    logic [31:0] wlog_a [64], wlog_d [64];
    int          wcnt = 0, wn = 0, ar_n = 0, done_reads = 0, p_reads = 0, proto_err = 0;

    assign awready = !aw_seen;
    assign wready  = bp ? (aw_seen && wcnt >= 2) : !w_seen;
    assign arready = !rvalid;
    assign rresp   = 2'b00;

    function automatic logic [31:0] pow(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r = 32'd1;
        for (int i = 0; i < int'(b); i++) r = r * a;
        return r;
    endfunction

    always @(posedge clk or posedge rst)
        if (rst) begin
            aw_seen <= 0; w_seen <= 0; bvalid <= 0; rvalid <= 0; bresp <= 0; rdata <= 0;
            wcnt <= 0; aw_pend <= 0; w_pend <= 0;
        end else begin
            wcnt    <= aw_seen ? wcnt + 1 : 0;
            aw_pend <= awvalid && !awready;
            w_pend  <= wvalid && !wready;
            aw_prev <= awaddr;
            w_prev  <= wdata;
            if ((aw_seen && awvalid) || (aw_pend && (!awvalid || awaddr != aw_prev)) ||
                (w_pend && (!wvalid || wdata != w_prev)) || (wvalid && wstrb != 4'hF))
                proto_err <= proto_err + 1;
            if (!awvalid && wvalid) split_seen <= 1;
            if (bvalid && bready) bvalid <= 0;
            if (rvalid && rready) rvalid <= 0;
            wa = (awvalid && awready) ? awaddr : aw_q;
            wd = (wvalid && wready) ? wdata : w_q;
            if ((aw_seen || (awvalid && awready)) && (w_seen || (wvalid && wready))) begin
                aw_seen <= 0; w_seen <= 0; bvalid <= 1;
                bresp <= (wa == err_addr) ? 2'b10 : 2'b00;
                wlog_a[wn % 64] <= wa;
                wlog_d[wn % 64] <= wd;
                wn <= wn + 1;
                if (wa == BASE) s_a <= wd;
                if (wa == BASE + 32'h4) s_b <= wd;
                if (wa == BASE + 32'h8) s_sel <= wd[0];
                if (wa == BASE + 32'hC) begin done_reads <= 0; p_reads <= 0; end
            end else begin
                if (awvalid && awready) begin aw_seen <= 1; aw_q <= awaddr; end
                if (wvalid && wready) begin w_seen <= 1; w_q <= wdata; end
            end
            if (arvalid && arready) begin
                rvalid <= 1;
                ar_n   <= ar_n + 1;
                if (araddr == BASE + 32'h14) begin
                    done_reads <= done_reads + 1;
                    rdata <= (done_after != 0 && done_reads + 1 >= done_after) ? 32'd1 : 32'd0;
                end else if (araddr == BASE + 32'h10) begin
                    p_reads <= p_reads + 1;
                    rdata <= s_sel ? pow(s_a, s_b) : s_a * s_b;
                end else rdata <= 32'hDEAD_BEEF;
            end
        end

    int passes = 0, checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input logic sel, output int lat);
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1;
        @(posedge clk);
        #1 cmd_valid = 0;
        lat = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (result_valid) begin lat = i; break; end
        end
        check("job_ended", lat != 0, 1);
    endtask

    int lat, w0, a0;
    logic [31:0] exp_d [4];

    initial begin
        cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_sel = 0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, result_valid}, 0);
        check("rst_addr", awaddr | araddr | wdata | {28'd0, wstrb}, 0);
        check("rst_result", {result_data, result_err}, 0);
        rst = 0;
        @(negedge clk);
        check("ready_after_rst", cmd_ready, 1);

        // multiply, zero-wait, DONE set on third poll
        w0 = wn;
        run_job(2, 3, 0, lat);
        check("mul_data", result_data, 6);
        check("mul_err", result_err, 0);
        check("mul_valid_cycle", lat + 1, 18);
        check("mul_writes", wn - w0, 4);
        exp_d[0] = 2; exp_d[1] = 3; exp_d[2] = 0; exp_d[3] = 1;
        for (int k = 0; k < 4; k++) begin
            check("mul_waddr", wlog_a[(w0 + k) % 64], BASE + 32'(4 * k));
            check("mul_wdata", wlog_d[(w0 + k) % 64], exp_d[k]);
        end
        check("mul_polls", done_reads, 3);
        check("mul_p_reads", p_reads, 1);
        @(negedge clk);
        check("valid_pulse", result_valid, 0);
        check("data_held", result_data, 6);

        // exponent
        run_job(2, 3, 1, lat);
        check("exp_data", result_data, 8);
        check("exp_err", result_err, 0);

        // write-data backpressure
        bp = 1; done_after = 1; w0 = wn;
        run_job(5, 7, 0, lat);
        check("bp_data", result_data, 35);
        check("bp_writes", wn - w0, 4);
        check("bp_split", split_seen, 1);
        bp = 0;

        // error response on SELECT write
        err_addr = BASE + 32'h8; w0 = wn; a0 = ar_n;
        run_job(4, 4, 0, lat);
        check("err_code", result_err, 1);
        check("err_writes", wn - w0, 3);
        check("err_reads", ar_n - a0, 0);
        err_addr = 32'hFFFF_FFFF;

        // poll timeout with POLL_LIMIT=4
        done_after = 0;
        run_job(9, 9, 0, lat);
        check("to_code", result_err, 2);
        check("to_polls", done_reads, 4);
        check("to_p_reads", p_reads, 0);

        // reset in the middle of the DONE poll
        @(negedge clk);
        cmd_a = 1; cmd_b = 1; cmd_sel = 0; cmd_valid = 1;
        @(posedge clk);
        #1 cmd_valid = 0;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (arvalid && araddr == BASE + 32'h14) begin lat = i; break; end
        end
        check("poll_reached", lat != 0, 1);
        #2 rst = 1;
        #1 check("rst_mid_ar", {arvalid, rready, cmd_ready, result_valid}, 0);
        @(negedge clk);
        rst = 0;
        done_after = 3; w0 = wn;
        run_job(6, 7, 0, lat);
        check("post_rst_data", result_data, 42);
        check("post_rst_err", result_err, 0);
        check("post_rst_cycle", lat + 1, 18);
        check("post_rst_writes", wn - w0, 4);
        check("axi_protocol", proto_err, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
